tsv_fp_rx_checker: RTL and testbench
====================================

Name: tsv_fp_rx_checker

Overview:
- Receive-side stage directly downstream of the 27-line DPS TSV encoder. It sits between the TSV bundle and the DPS 27-bit decoder.
- Registers each incoming 27-bit TSV codeword and checks it for forbidden 3-bit patterns (010 or 101 on any three adjacent lines).
- Buffers accepted words in a 2-entry FIFO with valid/ready handoff to the decoder.
- Keeps link statistics: word count, error count, and a capture of the first failing word.

Parameters:
- TSV_W, 27, TSV bundle width; fixed for this instance, must be >= 3.
- CNT_W, 16, width of the word and error counters; both saturate.

Ports:
- clock  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clear_stats  in  1  synchronous clear of counters and first-error capture; FIFO is unaffected.
- in_valid  in  1  tsv_in carries a codeword.
- in_ready  out  1  a word is accepted on the edge where in_valid && in_ready.
- tsv_in  in  TSV_W  received TSV codeword.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  the decoder consumes the head on the edge where out_valid && out_ready.
- tsv_out  out  TSV_W  FIFO head codeword.
- out_fp_err  out  1  FIFO head contained a forbidden pattern.
- word_count  out  CNT_W  number of accepted words (saturating).
- err_count  out  CNT_W  number of accepted words with at least one violation (saturating).
- err_first_valid  out  1  a first-error capture is held.
- err_first_word  out  TSV_W  codeword of the first failing word.
- err_first_pos  out  5  lowest violating position j of that word.
- err_first_index  out  CNT_W  word_count value at the time that word was accepted.

Behaviour:
- **Reset values:** reset=1 at an edge sets every output and all state to 0 (FIFO empty, out_valid=0, counters 0, capture cleared). in_ready reads 1 from the first cycle after reset. Reset overrides all other inputs, including mid-transfer.
- **Violation check:** combinational on tsv_in.
  - viol[j] = (tsv_in[j+2:j] == 3'b010) || (tsv_in[j+2:j] == 3'b101), for j = 0..TSV_W-3 (0..24 for 27 lines).
  - The top window (bits 26..24) is included.
  - fp_err = |viol; pos = index of the lowest set bit of viol.
- **FIFO:** 2 entries, each {tsv, fp_err}, with occupancy count 0..2.
  - in_ready = (count != 2). There is no same-cycle pass-through when full, even if out_ready=1.
  - out_valid = (count != 0). tsv_out and out_fp_err come from registered head storage.
  - Push and pop on the same edge: count is unchanged; head advances and the new word is appended in order.
  - Latency: a word accepted at edge N is visible on out_valid/tsv_out after edge N (one cycle).
  - Data ordering is strictly FIFO.
  - tsv_out is held stable while out_valid=1 and out_ready=0.
- **Statistics (update only on accept):**
  - word_count increments by 1, saturating at 2^CNT_W-1.
  - If fp_err: err_count increments by 1, saturating.
  - If fp_err and err_first_valid=0: capture err_first_word=tsv_in, err_first_pos=pos, err_first_index=word_count (pre-increment value), and set err_first_valid=1.
  - The capture holds until reset or clear_stats.
- **clear_stats:** zeroes word_count, err_count and the capture. If a word is accepted on the same edge, the clear is applied first and then the accepted word is counted. Result: word_count=1; err_count=1 if that word has fp_err (with capture, index 0), else 0.
- **Undriven/X inputs:** out_ready is ignored when out_valid=0. tsv_in is ignored when in_valid=0.

Test Plan:
1. Reset, then push 27'h0000000, 27'h7FFFFFF and 27'h0000003 with out_ready=1 -> three outputs in order, each 1 cycle after accept, all out_fp_err=0; word_count=3, err_count=0, err_first_valid=0.
2. Push 27'h0000005 (101 at bits 2:0), then 27'h5000000 (101 at bits 26:24) -> out_fp_err=1 for both; err_count=2; err_first_word=27'h0000005, err_first_pos=0, err_first_index=0. Capture stays on the first word.
3. With out_ready=0 and in_valid=1, offer words A, B, C -> A and B accepted; in_ready=0 after the second accept, C not accepted. Raise out_ready -> A, B, C delivered in order with no loss or duplication.
4. With the FIFO holding 1 entry, assert in_valid and out_ready together for 10 cycles -> count stays 1, one word in and one out per cycle, order preserved.
5. CNT_W=4: push 20 copies of 27'h0000002 (010 at bits 2:0) -> err_count and word_count saturate at 15; err_first_pos=0, err_first_index=0.
6. Assert clear_stats on the same edge as accepting 27'h0000010 (010 at bits 5:3) -> word_count=1, err_count=1, err_first_pos=3, err_first_index=0. A reset pulse while the FIFO holds 2 entries -> out_valid=0, in_ready=1 and counters 0 on the next cycle.

Source files
------------

// File: rtl/tsv_fp_rx_checker_if.sv
// Valid/ready codeword link between TSV receive stages.
// Master drives valid and data; slave returns ready.
interface tsv_fp_rx_checker_if #(
    parameter int W = 27
);
    logic         tsv_vld;
    logic         tsv_rdy;
    logic [W-1:0] tsv_dat;

    modport master (output tsv_vld, output tsv_dat, input tsv_rdy);
    modport slave  (input tsv_vld, input tsv_dat, output tsv_rdy);
endinterface

// File: rtl/tsv_fp_rx_checker.sv
// TSV receive checker: flags 010/101 windows, buffers words in a 2-deep FIFO, keeps link stats.
// Latency 1 cycle accept-to-head; in ready drops only when both slots are full (no pass-through).
module tsv_fp_rx_checker #(
    parameter int TSV_W = 27,
    parameter int CNT_W = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_stats_i,
    tsv_fp_rx_checker_if.slave  in_if,
    tsv_fp_rx_checker_if.master out_if,
    output logic             out_fp_err_o,
    output logic [CNT_W-1:0] word_count_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic             err_first_valid_o,
    output logic [TSV_W-1:0] err_first_word_o,
    output logic [4:0]       err_first_pos_o,
    output logic [CNT_W-1:0] err_first_index_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [TSV_W-3:0] viol;
    logic             fp_err;
    logic [4:0]       pos;

    always_comb begin
        logic [2:0] win;
        win  = '0;
        viol = '0;
        for (int j = 0; j < TSV_W - 2; j++) begin
            win     = in_if.tsv_dat[j +: 3];
            viol[j] = (win == 3'b010) || (win == 3'b101);
        end
    end

    assign fp_err = |viol;

    // Scan downwards so the lowest violating window wins.
    always_comb begin
        pos = '0;
        for (int j = TSV_W - 3; j >= 0; j--) begin
            if (viol[j]) pos = 5'(j);
        end
    end

    logic [1:0]       count_q, count_d;
    logic [TSV_W-1:0] slot0_dat_q, slot0_dat_d, slot1_dat_q, slot1_dat_d;
    logic             slot0_err_q, slot0_err_d, slot1_err_q, slot1_err_d;
    logic             push, pop;

    assign in_if.tsv_rdy  = (count_q != 2'd2);
    assign out_if.tsv_vld = (count_q != 2'd0);
    assign out_if.tsv_dat = slot0_dat_q;
    assign out_fp_err_o   = slot0_err_q;

    assign push = in_if.tsv_vld && in_if.tsv_rdy;
    assign pop  = out_if.tsv_vld && out_if.tsv_rdy;

    // Slot 0 is always the head; slot 1 only ever holds the second-oldest word.
    always_comb begin
        count_d     = count_q;
        slot0_dat_d = slot0_dat_q;
        slot0_err_d = slot0_err_q;
        slot1_dat_d = slot1_dat_q;
        slot1_err_d = slot1_err_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    slot0_dat_d = in_if.tsv_dat;
                    slot0_err_d = fp_err;
                    count_d     = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    slot0_dat_d = in_if.tsv_dat;
                    slot0_err_d = fp_err;
                end else if (push) begin
                    slot1_dat_d = in_if.tsv_dat;
                    slot1_err_d = fp_err;
                    count_d     = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    slot0_dat_d = slot1_dat_q;
                    slot0_err_d = slot1_err_q;
                    count_d     = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q     <= '0;
            slot0_dat_q <= '0;
            slot0_err_q <= 1'b0;
            slot1_dat_q <= '0;
            slot1_err_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            slot0_dat_q <= slot0_dat_d;
            slot0_err_q <= slot0_err_d;
            slot1_dat_q <= slot1_dat_d;
            slot1_err_q <= slot1_err_d;
        end
    end

    logic [CNT_W-1:0] wc_q, wc_d, ec_q, ec_d, fi_q, fi_d;
    logic [CNT_W-1:0] wc_base, ec_base;
    logic             fv_q, fv_d, fv_base;
    logic [TSV_W-1:0] fw_q, fw_d;
    logic [4:0]       fp_q, fp_d;

    // A clear on the same edge as an accept is applied first, then the word is counted.
    always_comb begin
        wc_base = clear_stats_i ? '0 : wc_q;
        ec_base = clear_stats_i ? '0 : ec_q;
        fv_base = clear_stats_i ? 1'b0 : fv_q;
        wc_d    = wc_base;
        ec_d    = ec_base;
        fv_d    = fv_base;
        fw_d    = clear_stats_i ? '0 : fw_q;
        fp_d    = clear_stats_i ? '0 : fp_q;
        fi_d    = clear_stats_i ? '0 : fi_q;
        if (push) begin
            if (wc_base != CNT_MAX) wc_d = wc_base + 1'b1;
            if (fp_err) begin
                if (ec_base != CNT_MAX) ec_d = ec_base + 1'b1;
                if (!fv_base) begin
                    fv_d = 1'b1;
                    fw_d = in_if.tsv_dat;
                    fp_d = pos;
                    fi_d = wc_base;
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wc_q <= '0;
            ec_q <= '0;
            fv_q <= 1'b0;
            fw_q <= '0;
            fp_q <= '0;
            fi_q <= '0;
        end else begin
            wc_q <= wc_d;
            ec_q <= ec_d;
            fv_q <= fv_d;
            fw_q <= fw_d;
            fp_q <= fp_d;
            fi_q <= fi_d;
        end
    end

    assign word_count_o      = wc_q;
    assign err_count_o       = ec_q;
    assign err_first_valid_o = fv_q;
    assign err_first_word_o  = fw_q;
    assign err_first_pos_o   = fp_q;
    assign err_first_index_o = fi_q;

endmodule

// File: tb/tb_tsv_fp_rx_checker.sv
// Randomized bench for tsv_fp_rx_checker against a queue-based reference model.
// Two instances share stimulus: default counters and 4-bit counters for saturation.
module tb_tsv_fp_rx_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, in_vld, out_rdy, en;
    logic [26:0] in_dat;

    tsv_fp_rx_checker_if #(.W(27)) in_a  ();
    tsv_fp_rx_checker_if #(.W(27)) out_a ();
    tsv_fp_rx_checker_if #(.W(27)) in_b  ();
    tsv_fp_rx_checker_if #(.W(27)) out_b ();

    assign in_a.tsv_vld  = in_vld;
    assign in_a.tsv_dat  = in_dat;
    assign in_b.tsv_vld  = in_vld;
    assign in_b.tsv_dat  = in_dat;
    assign out_a.tsv_rdy = out_rdy;
    assign out_b.tsv_rdy = out_rdy;

    logic        err_a, err_b, fv_a, fv_b;
    logic [15:0] wc_a, ec_a, fi_a;
    logic [3:0]  wc_b, ec_b, fi_b;
    logic [26:0] fw_a, fw_b;
    logic [4:0]  fp_a, fp_b;

    tsv_fp_rx_checker #(.TSV_W(27), .CNT_W(16)) dut_a (
        .clock_i(clk), .reset_i(rst), .clear_stats_i(clr),
        .in_if(in_a), .out_if(out_a), .out_fp_err_o(err_a),
        .word_count_o(wc_a), .err_count_o(ec_a), .err_first_valid_o(fv_a),
        .err_first_word_o(fw_a), .err_first_pos_o(fp_a), .err_first_index_o(fi_a)
    );

    tsv_fp_rx_checker #(.TSV_W(27), .CNT_W(4)) dut_b (
        .clock_i(clk), .reset_i(rst), .clear_stats_i(clr),
        .in_if(in_b), .out_if(out_b), .out_fp_err_o(err_b),
        .word_count_o(wc_b), .err_count_o(ec_b), .err_first_valid_o(fv_b),
        .err_first_word_o(fw_b), .err_first_pos_o(fp_b), .err_first_index_o(fi_b)
    );

    typedef struct {
        logic [26:0] d;
        bit          e;
    } ent_t;

    ent_t        q[$];
    logic [26:0] src[$];
    int wc[2], ec[2], fv[2], fw[2], fpos[2], fi[2];
    int mx[2] = '{65535, 15};
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Lowest j where lines j..j+2 alternate, -1 if the word is clean.
    function automatic int ref_pos(input logic [26:0] w);
        int b0, b1, b2;
        for (int j = 0; j <= 24; j++) begin
            b0 = int'(w[j]);
            b1 = int'(w[j+1]);
            b2 = int'(w[j+2]);
            if (b0 != b1 && b1 != b2) return j;
        end
        return -1;
    endfunction

    // Paired bits never alternate, so these words are clean by construction.
    function automatic logic [26:0] gen_word();
        logic [26:0] w;
        logic [12:0] r;
        if ($urandom_range(0, 1) == 0) return 27'($urandom);
        r = 13'($urandom);
        w = '0;
        for (int i = 0; i < 13; i++) begin
            w[2*i]   = r[i];
            w[2*i+1] = r[i];
        end
        w[26] = w[25];
        return w;
    endfunction

    task automatic compare_all();
        check("a.in_ready",  32'(in_a.tsv_rdy),  32'(q.size() != 2));
        check("a.out_valid", 32'(out_a.tsv_vld), 32'(q.size() != 0));
        check("b.in_ready",  32'(in_b.tsv_rdy),  32'(q.size() != 2));
        check("b.out_valid", 32'(out_b.tsv_vld), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("a.tsv_out",    32'(out_a.tsv_dat), 32'(q[0].d));
            check("a.out_fp_err", 32'(err_a),         32'(q[0].e));
            check("b.tsv_out",    32'(out_b.tsv_dat), 32'(q[0].d));
            check("b.out_fp_err", 32'(err_b),         32'(q[0].e));
        end
        check("a.word_count", 32'(wc_a), wc[0]);
        check("a.err_count",  32'(ec_a), ec[0]);
        check("a.first_vld",  32'(fv_a), fv[0]);
        check("a.first_word", 32'(fw_a), fw[0]);
        check("a.first_pos",  32'(fp_a), fpos[0]);
        check("a.first_idx",  32'(fi_a), fi[0]);
        check("b.word_count", 32'(wc_b), wc[1]);
        check("b.err_count",  32'(ec_b), ec[1]);
        check("b.first_vld",  32'(fv_b), fv[1]);
        check("b.first_word", 32'(fw_b), fw[1]);
        check("b.first_pos",  32'(fp_b), fpos[1]);
        check("b.first_idx",  32'(fi_b), fi[1]);
    endtask

    task automatic tick();
        bit acc, pop;
        int p;
        ent_t e;
        in_vld = en && (src.size() != 0);
        in_dat = (src.size() != 0) ? src[0] : 27'($urandom);
        @(posedge clk);
        if (rst) begin
            q.delete();
            for (int k = 0; k < 2; k++) begin
                wc[k] = 0; ec[k] = 0; fv[k] = 0; fw[k] = 0; fpos[k] = 0; fi[k] = 0;
            end
        end else begin
            acc = in_vld && (q.size() < 2);
            pop = out_rdy && (q.size() > 0);
            p   = ref_pos(in_dat);
            for (int k = 0; k < 2; k++) begin
                if (clr) begin
                    wc[k] = 0; ec[k] = 0; fv[k] = 0; fw[k] = 0; fpos[k] = 0; fi[k] = 0;
                end
                if (acc) begin
                    if (p >= 0 && fv[k] == 0) begin
                        fv[k] = 1; fw[k] = int'(in_dat); fpos[k] = p; fi[k] = wc[k];
                    end
                    if (wc[k] < mx[k]) wc[k]++;
                    if (p >= 0 && ec[k] < mx[k]) ec[k]++;
                end
            end
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.d = in_dat;
                e.e = (p >= 0);
                q.push_back(e);
                void'(src.pop_front());
            end
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; out_rdy = 1'b0; en = 1'b0;
        in_vld = 1'b0; in_dat = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Clean words streamed straight through.
        src.push_back(27'h0000000);
        src.push_back(27'h7FFFFFF);
        src.push_back(27'h0000003);
        en = 1'b1; out_rdy = 1'b1;
        repeat (6) tick();
        check("t1_word_count", 32'(wc_a), 32'd3);
        check("t1_err_count",  32'(ec_a), 32'd0);
        check("t1_first_vld",  32'(fv_a), 32'd0);

        // Violations at the bottom and top windows.
        do_reset();
        src.push_back(27'h0000005);
        src.push_back(27'h5000000);
        repeat (5) tick();
        check("t2_err_count",  32'(ec_a), 32'd2);
        check("t2_first_word", 32'(fw_a), 32'h0000005);
        check("t2_first_pos",  32'(fp_a), 32'd0);
        check("t2_first_idx",  32'(fi_a), 32'd0);

        // Backpressure: third word must wait.
        out_rdy = 1'b0;
        src.push_back(27'h1111111);
        src.push_back(27'h2222222);
        src.push_back(27'h3333333);
        repeat (4) tick();
        check("t3_in_ready_full", 32'(in_a.tsv_rdy), 32'd0);
        check("t3_src_left",      32'(src.size()),   32'd1);
        out_rdy = 1'b1;
        repeat (6) tick();

        // Steady push+pop with one entry held.
        out_rdy = 1'b0;
        src.push_back(gen_word());
        tick();
        for (int i = 0; i < 10; i++) src.push_back(gen_word());
        out_rdy = 1'b1;
        repeat (10) tick();
        check("t4_occupancy", 32'(q.size()), 32'd1);
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;

        // Saturation of the 4-bit counters.
        do_reset();
        for (int i = 0; i < 20; i++) src.push_back(27'h0000002);
        repeat (24) tick();
        check("t5_sat_word_count", 32'(wc_b), 32'd15);
        check("t5_sat_err_count",  32'(ec_b), 32'd15);
        check("t5_first_pos",      32'(fp_b), 32'd0);
        check("t5_first_idx",      32'(fi_b), 32'd0);

        // Clear coinciding with an accept.
        src.push_back(27'h0000010);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t6_word_count", 32'(wc_a), 32'd1);
        check("t6_err_count",  32'(ec_a), 32'd1);
        check("t6_first_pos",  32'(fp_a), 32'd3);
        check("t6_first_idx",  32'(fi_a), 32'd0);

        // Reset while full.
        out_rdy = 1'b0;
        src.push_back(27'h00000FF);
        src.push_back(27'h0000F00);
        repeat (3) tick();
        do_reset();
        check("t6_rst_out_valid", 32'(out_a.tsv_vld), 32'd0);
        check("t6_rst_in_ready",  32'(in_a.tsv_rdy),  32'd1);
        check("t6_rst_word_cnt",  32'(wc_a),          32'd0);
        src.delete();

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 500; i++) begin
            while (src.size() < 3) src.push_back(gen_word());
            en      = ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            clr     = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
